// File: rtl/minsoc_rst_sequencer_if.sv
// Reset-sequencer status/control bundle.
// The board side drives clock-lock status and software reset requests. The
// sequencer side drives the staged domain resets, the busy flag and the
// cause of the last reset.
interface minsoc_rst_sequencer_if;
    logic       clk_locked;
    logic       sw_rst_req;
    logic       wb_rst;
    logic       eth_rst;
    logic       cpu_rst;
    logic       rst_busy;
    logic [1:0] rst_cause;

    // Board / environment side: requests in, domain resets observed.
    modport master (
        output clk_locked,
        output sw_rst_req,
        input  wb_rst,
        input  eth_rst,
        input  cpu_rst,
        input  rst_busy,
        input  rst_cause
    );

    // Sequencer side: requests observed, domain resets driven.
    modport slave (
        input  clk_locked,
        input  sw_rst_req,
        output wb_rst,
        output eth_rst,
        output cpu_rst,
        output rst_busy,
        output rst_cause
    );
endinterface

// File: rtl/minsoc_rst_sequencer.sv
// Staged reset sequencer for the SoC.
// Holds every domain in reset for a stretch of locked clock cycles, then
// releases the Wishbone fabric, the Ethernet MAC and the CPU in that order,
// one stage gap apart. Debounced lock loss or a software request in RUN
// reasserts all domains together and restarts the sequence; the cause of
// the most recent reset is kept on rst_cause.
module minsoc_rst_sequencer #(
    parameter int STRETCH_CYCLES = 16,
    parameter int STAGE_GAP      = 4,
    parameter int DEBOUNCE       = 3,
    parameter int CNT_W          = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    minsoc_rst_sequencer_if.slave rst_if
);

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_REL_WB  = 2'd1,
        ST_REL_ETH = 2'd2,
        ST_RUN     = 2'd3
    } state_t;

    localparam logic [1:0] CAUSE_EXT  = 2'b01;
    localparam logic [1:0] CAUSE_LOCK = 2'b10;
    localparam logic [1:0] CAUSE_SW   = 2'b11;

    localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(STAGE_GAP - 1);
    // One extra bit so the low-sample counter can hold DEBOUNCE itself.
    localparam logic [CNT_W:0]   LO_MAX       = (CNT_W + 1)'(DEBOUNCE);
    localparam logic [CNT_W:0]   LO_LAST      = (CNT_W + 1)'(DEBOUNCE - 1);

    state_t           state,    state_nxt;
    logic [CNT_W-1:0] cnt,      cnt_nxt;
    logic [CNT_W:0]   lo_cnt,   lo_cnt_nxt;
    logic             wb_q,     wb_nxt;
    logic             eth_q,    eth_nxt;
    logic             cpu_q,    cpu_nxt;
    logic             busy_q,   busy_nxt;
    logic [1:0]       cause_q,  cause_nxt;
    logic             lock_lost;
    logic             sw_hit;

    // Trigger conditions: the DEBOUNCE-th consecutive low sample outside the
    // stretch phase, or a software request once the sequence has completed.
    assign lock_lost = (state != ST_ASSERT) && !rst_if.clk_locked && (lo_cnt == LO_LAST);
    assign sw_hit    = (state == ST_RUN) && rst_if.sw_rst_req;

    // Next-state, counter and output-register computation.
    // NOTE: every variable gets a default at the top of the block, so no path
    // can leave one unassigned and infer a latch.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        lo_cnt_nxt = lo_cnt;
        wb_nxt     = wb_q;
        eth_nxt    = eth_q;
        cpu_nxt    = cpu_q;
        busy_nxt   = busy_q;
        cause_nxt  = cause_q;

        // Consecutive low-sample counter, saturating at DEBOUNCE.
        if (rst_if.clk_locked) begin
            lo_cnt_nxt = '0;
        end else if (lo_cnt != LO_MAX) begin
            lo_cnt_nxt = lo_cnt + (CNT_W + 1)'(1);
        end

        unique case (state)
            ST_ASSERT: begin
                // Only uninterrupted locked cycles count towards the stretch.
                if (!rst_if.clk_locked) begin
                    cnt_nxt = '0;
                end else if (cnt == STRETCH_LAST) begin
                    wb_nxt    = 1'b0;
                    cnt_nxt   = '0;
                    state_nxt = ST_REL_WB;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_REL_WB: begin
                if (cnt == GAP_LAST) begin
                    eth_nxt   = 1'b0;
                    cnt_nxt   = '0;
                    state_nxt = ST_REL_ETH;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_REL_ETH: begin
                if (cnt == GAP_LAST) begin
                    cpu_nxt   = 1'b0;
                    busy_nxt  = 1'b0;
                    cnt_nxt   = '0;
                    state_nxt = ST_RUN;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_RUN: begin
                cnt_nxt = cnt;
            end
            default: begin
                state_nxt = ST_ASSERT;
            end
        endcase

        // Re-entry reasserts every domain in the same cycle and restarts the
        // full stretch; lock loss wins over a simultaneous software request.
        if (lock_lost || sw_hit) begin
            state_nxt  = ST_ASSERT;
            cnt_nxt    = '0;
            lo_cnt_nxt = '0;
            wb_nxt     = 1'b1;
            eth_nxt    = 1'b1;
            cpu_nxt    = 1'b1;
            busy_nxt   = 1'b1;
            cause_nxt  = lock_lost ? CAUSE_LOCK : CAUSE_SW;
        end
    end

    // State, counters and registered outputs; reset overrides everything.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= ST_ASSERT;
            cnt     <= '0;
            lo_cnt  <= '0;
            wb_q    <= 1'b1;
            eth_q   <= 1'b1;
            cpu_q   <= 1'b1;
            busy_q  <= 1'b1;
            cause_q <= CAUSE_EXT;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            lo_cnt  <= lo_cnt_nxt;
            wb_q    <= wb_nxt;
            eth_q   <= eth_nxt;
            cpu_q   <= cpu_nxt;
            busy_q  <= busy_nxt;
            cause_q <= cause_nxt;
        end
    end

    assign rst_if.wb_rst    = wb_q;
    assign rst_if.eth_rst   = eth_q;
    assign rst_if.cpu_rst   = cpu_q;
    assign rst_if.rst_busy  = busy_q;
    assign rst_if.rst_cause = cause_q;

endmodule

// File: tb/tb_minsoc_rst_sequencer.sv
// Bench for minsoc_rst_sequencer.
// A driver applies directed scenarios followed by random lock/software/reset
// traffic. A reference model computes each cycle's expected outputs from a
// single "progress" count and pushes them into a queue; a monitor pops one
// entry per cycle and compares it with the DUT, plus the ordering invariant.
module tb_minsoc_rst_sequencer;

    localparam int S = 16;
    localparam int G = 4;
    localparam int D = 3;

    typedef struct packed {
        logic       wb;
        logic       eth;
        logic       cpu;
        logic       busy;
        logic [1:0] cause;
    } exp_t;

    logic clock;
    logic reset;
    int   total;
    int   bad;
    exp_t exp_q[$];

    minsoc_rst_sequencer_if rif ();

    minsoc_rst_sequencer #(
        .STRETCH_CYCLES(S),
        .STAGE_GAP     (G),
        .DEBOUNCE      (D),
        .CNT_W         (8)
    ) dut (
        .clock (clock),
        .reset (reset),
        .rst_if(rif.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model. "el" is how far the release sequence has progressed:
    // during the stretch only consecutive locked cycles count, afterwards
    // every cycle counts, up to S+2G where the sequence is complete.
    initial begin : model
        int         el;
        int         streak;
        logic [1:0] cause;
        exp_t       e;
        el = 0;
        streak = 0;
        cause = 2'b00;
        forever begin
            @(posedge clock);
            if (reset) begin
                el = 0;
                streak = 0;
                cause = 2'b01;
            end else begin
                if (!rif.clk_locked) streak++;
                else streak = 0;
                if (el >= S && !rif.clk_locked && streak == D) begin
                    el = 0;
                    streak = 0;
                    cause = 2'b10;
                end else if (el == S + 2 * G && rif.sw_rst_req) begin
                    el = 0;
                    streak = 0;
                    cause = 2'b11;
                end else if (el < S) begin
                    el = rif.clk_locked ? el + 1 : 0;
                end else if (el < S + 2 * G) begin
                    el++;
                end
            end
            e.wb    = (el < S);
            e.eth   = (el < S + G);
            e.cpu   = (el < S + 2 * G);
            e.busy  = (el < S + 2 * G);
            e.cause = cause;
            exp_q.push_back(e);
        end
    end

    // Monitor: one expected entry per clock, compared away from the edge.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("wb_rst",    {7'd0, rif.wb_rst},   {7'd0, e.wb});
                check("eth_rst",   {7'd0, rif.eth_rst},  {7'd0, e.eth});
                check("cpu_rst",   {7'd0, rif.cpu_rst},  {7'd0, e.cpu});
                check("rst_busy",  {7'd0, rif.rst_busy}, {7'd0, e.busy});
                check("rst_cause", {6'd0, rif.rst_cause}, {6'd0, e.cause});
                check("order_cpu_eth", {7'd0, (!rif.cpu_rst && rif.eth_rst)}, 8'd0);
                check("order_eth_wb",  {7'd0, (!rif.eth_rst && rif.wb_rst)},  8'd0);
            end
        end
    end

    // One clock: inputs applied at the falling edge, held across the rising edge.
    task automatic step(input logic r, input logic l, input logic s);
        reset          = r;
        rif.clk_locked = l;
        rif.sw_rst_req = s;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic run(input int n, input logic l, input logic s);
        for (int i = 0; i < n; i++) step(1'b0, l, s);
    endtask

    task automatic expect_rsts(input string name, input logic w, input logic e,
                               input logic c, input logic [1:0] cause);
        check({name, "_wb"},    {7'd0, rif.wb_rst},    {7'd0, w});
        check({name, "_eth"},   {7'd0, rif.eth_rst},   {7'd0, e});
        check({name, "_cpu"},   {7'd0, rif.cpu_rst},   {7'd0, c});
        check({name, "_cause"}, {6'd0, rif.rst_cause}, {6'd0, cause});
    endtask

    initial begin : driver
        int burst;
        total = 0;
        bad = 0;
        reset = 1'b1;
        rif.clk_locked = 1'b1;
        rif.sw_rst_req = 1'b0;
        @(negedge clock);

        // 1: power-up release timing.
        for (int i = 0; i < 18; i++) step(1'b1, 1'b1, 1'b0);
        expect_rsts("in_reset", 1, 1, 1, 2'b01);
        run(15, 1'b1, 1'b0);
        expect_rsts("pu_e15", 1, 1, 1, 2'b01);
        run(1, 1'b1, 1'b0);
        expect_rsts("pu_e16", 0, 1, 1, 2'b01);
        run(4, 1'b1, 1'b0);
        expect_rsts("pu_e20", 0, 0, 1, 2'b01);
        run(3, 1'b1, 1'b0);
        expect_rsts("pu_e23", 0, 0, 1, 2'b01);
        run(1, 1'b1, 1'b0);
        expect_rsts("pu_e24", 0, 0, 0, 2'b01);
        check("pu_busy", {7'd0, rif.rst_busy}, 8'd0);

        // 2: clock locks late; stretch counts from lock.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
        run(10, 1'b0, 1'b0);
        run(15, 1'b1, 1'b0);
        expect_rsts("late_l15", 1, 1, 1, 2'b01);
        run(1, 1'b1, 1'b0);
        expect_rsts("late_l16", 0, 1, 1, 2'b01);
        run(8, 1'b1, 1'b0);
        expect_rsts("late_run", 0, 0, 0, 2'b01);

        // 3: short glitch ignored, debounced loss resequences.
        run(2, 1'b0, 1'b0);
        run(1, 1'b1, 1'b0);
        expect_rsts("glitch2", 0, 0, 0, 2'b01);
        run(3, 1'b0, 1'b0);
        expect_rsts("glitch3", 1, 1, 1, 2'b10);
        run(23, 1'b1, 1'b0);
        expect_rsts("reseq_23", 0, 0, 1, 2'b10);
        run(1, 1'b1, 1'b0);
        expect_rsts("reseq_24", 0, 0, 0, 2'b10);

        // 4: software request in RUN; ignored during REL_WB.
        run(1, 1'b1, 1'b1);
        expect_rsts("sw_run", 1, 1, 1, 2'b11);
        run(16, 1'b1, 1'b0);
        run(1, 1'b1, 1'b1);
        expect_rsts("sw_relwb", 0, 1, 1, 2'b11);
        run(6, 1'b1, 1'b0);
        expect_rsts("sw_e23", 0, 0, 1, 2'b11);
        run(1, 1'b1, 1'b0);
        expect_rsts("sw_e24", 0, 0, 0, 2'b11);

        // 5: lock loss and software request on the same cycle.
        run(2, 1'b0, 1'b0);
        run(1, 1'b0, 1'b1);
        expect_rsts("collide", 1, 1, 1, 2'b10);

        // 6: external reset while in REL_ETH.
        run(21, 1'b1, 1'b0);
        expect_rsts("mid_releth", 0, 0, 1, 2'b10);
        step(1'b1, 1'b1, 1'b0);
        expect_rsts("mid_reset", 1, 1, 1, 2'b01);
        run(24, 1'b1, 1'b0);
        expect_rsts("mid_rerun", 0, 0, 0, 2'b01);

        // Random traffic: low bursts, software pulses, occasional reset.
        burst = 0;
        for (int i = 0; i < 3000; i++) begin
            logic l;
            logic s;
            logic r;
            if (burst == 0 && $urandom_range(0, 99) < 2) burst = $urandom_range(1, 5);
            l = (burst == 0);
            if (burst != 0) burst--;
            s = ($urandom_range(0, 99) < 2);
            r = ($urandom_range(0, 999) < 4);
            step(r, l, s);
        end

        @(negedge clock);
        check("queue_drained", 8'(exp_q.size() > 1), 8'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
